// File: rtl/tinyalu_pkg.sv
// Shared opcode definitions and helpers for the parametrised pipelined ALU.
// Opcodes 11..15 are reserved and complete with an error pulse.
package tinyalu_pkg;

    typedef enum logic [3:0] {
        op_nop  = 4'd0,
        op_add  = 4'd1,
        op_and  = 4'd2,
        op_xor  = 4'd3,
        op_mul  = 4'd4,
        op_sp0  = 4'd5,
        op_sp1  = 4'd6,
        op_sp2  = 4'd7,
        op_shl  = 4'd8,
        op_shr  = 4'd9,
        op_nop1 = 4'd10,
        op_res1 = 4'd11,
        op_res2 = 4'd12,
        op_res3 = 4'd13,
        op_res4 = 4'd14,
        op_res5 = 4'd15
    } alu_opcode_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_EXEC = 1'b1
    } alu_state_t;

    // Wide enough for MUL_STAGES+1 with MUL_STAGES up to 8.
    localparam int CNT_W = 4;

    function automatic logic is_multi(input alu_opcode_t o);
        return (o == op_mul) || (o == op_sp0) || (o == op_sp1) || (o == op_sp2);
    endfunction

    function automatic logic is_reserved(input alu_opcode_t o);
        return o >= op_res1;
    endfunction

endpackage

// File: rtl/alu_mul_pipe.sv
// Registered multiply/scale pipeline (MUL_STAGES-1 stages) with a trailing
// post-add stage used only by sp0 (A + 2*B).
module alu_mul_pipe
    import tinyalu_pkg::*;
#(
    parameter int W          = 8,
    parameter int MUL_STAGES = 3
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            load,
    input  logic [W-1:0]    a,
    input  logic [W-1:0]    b,
    input  alu_opcode_t     op,
    output logic [2*W-1:0]  mul_out,
    output logic [2*W-1:0]  sp0_out
);

    localparam int NS = MUL_STAGES - 1;

    logic [2*W-1:0] a_ext;
    logic [2*W-1:0] b_ext;
    logic [2*W-1:0] prod_in;
    logic [2*W-1:0] sum_reg;

    always_comb begin
        a_ext = {{W{1'b0}}, a};
        b_ext = {{W{1'b0}}, b};
        prod_in = '0;
        case (op)
            op_mul:  prod_in = a_ext * b_ext;
            op_sp1:  prod_in = a_ext << 1;
            op_sp2:  prod_in = a_ext + (a_ext << 1);
            op_sp0:  prod_in = b_ext << 1;
            default: prod_in = '0;
        endcase
    end

    // Operand A travels alongside the scaled value so sp0 can add it at the end.
    for (genvar gi = 0; gi < NS; gi++) begin : g_stage
        logic [2*W-1:0] prod_reg;
        logic [W-1:0]   a_reg;
        if (gi == 0) begin : g_head
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    prod_reg <= '0;
                    a_reg    <= '0;
                end else if (load) begin
                    prod_reg <= prod_in;
                    a_reg    <= a;
                end
            end
        end else begin : g_tail
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    prod_reg <= '0;
                    a_reg    <= '0;
                end else begin
                    prod_reg <= g_stage[gi-1].prod_reg;
                    a_reg    <= g_stage[gi-1].a_reg;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sum_reg <= '0;
        end else begin
            sum_reg <= g_stage[NS-1].prod_reg + {{W{1'b0}}, g_stage[NS-1].a_reg};
        end
    end

    assign mul_out = g_stage[NS-1].prod_reg;
    assign sp0_out = sum_reg;

endmodule

// File: rtl/alu_pipe_param.sv
// Parametrised ALU with unified issue/retire control: single-cycle ops retire
// from IDLE, multi-cycle ops park in EXEC until the pipeline result is ready.
module alu_pipe_param
    import tinyalu_pkg::*;
#(
    parameter int W          = 8,
    parameter int MUL_STAGES = 3,
    parameter int SHIFT_AMT  = 3
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [W-1:0]    A,
    input  logic [W-1:0]    B,
    input  alu_opcode_t     op,
    input  logic            start,
    output logic            busy,
    output logic            done,
    output logic [2*W-1:0]  result,
    output logic            error,
    output logic            overrun
);

    localparam logic [CNT_W-1:0] LOAD_MUL = CNT_W'(MUL_STAGES - 1);
    localparam logic [CNT_W-1:0] LOAD_SP0 = CNT_W'(MUL_STAGES);

    alu_state_t       state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    alu_opcode_t      op_reg, op_next;
    logic             done_reg, done_next;
    logic             error_reg, error_next;
    logic             overrun_reg, overrun_next;
    logic [2*W-1:0]   result_reg, result_next;
    logic [2*W-1:0]   mul_out, sp0_out;
    logic             accept;
    logic             pipe_load;

    function automatic logic [2*W-1:0] single_eval(input alu_opcode_t o,
                                                   input logic [W-1:0] a,
                                                   input logic [W-1:0] b);
        logic [2*W-1:0] ae;
        logic [2*W-1:0] be;
        logic [2*W-1:0] r;
        ae = {{W{1'b0}}, a};
        be = {{W{1'b0}}, b};
        case (o)
            op_add:  r = ae + be;
            op_and:  r = ae & be;
            op_xor:  r = ae ^ be;
            op_shl:  r = ae << SHIFT_AMT;
            op_shr:  r = ae >> SHIFT_AMT;
            default: r = '0;
        endcase
        return r;
    endfunction

    assign busy      = (state_reg == ST_EXEC);
    assign accept    = start && !busy;
    assign pipe_load = accept && is_multi(op);

    alu_mul_pipe #(
        .W          (W),
        .MUL_STAGES (MUL_STAGES)
    ) u_mul_pipe (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (pipe_load),
        .a       (A),
        .b       (B),
        .op      (op),
        .mul_out (mul_out),
        .sp0_out (sp0_out)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
            op_reg    <= op_nop;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            op_reg    <= op_next;
        end
    end

    // Counter is loaded with latency-1 and retires when it steps to zero.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        op_next    = op_reg;
        case (state_reg)
            ST_IDLE: begin
                if (pipe_load) begin
                    state_next = ST_EXEC;
                    op_next    = op;
                    cnt_next   = (op == op_sp0) ? LOAD_SP0 : LOAD_MUL;
                end
            end
            ST_EXEC: begin
                cnt_next = cnt_reg - CNT_W'(1);
                if (cnt_reg == CNT_W'(1)) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        done_next    = 1'b0;
        error_next   = 1'b0;
        result_next  = result_reg;
        overrun_next = start && busy;
        if (state_reg == ST_IDLE) begin
            if (accept && !is_multi(op) && (op != op_nop) && (op != op_nop1)) begin
                done_next = 1'b1;
                if (is_reserved(op)) begin
                    error_next  = 1'b1;
                    result_next = '0;
                end else begin
                    result_next = single_eval(op, A, B);
                end
            end
        end else if (cnt_reg == CNT_W'(1)) begin
            done_next   = 1'b1;
            result_next = (op_reg == op_sp0) ? sp0_out : mul_out;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            done_reg    <= 1'b0;
            error_reg   <= 1'b0;
            overrun_reg <= 1'b0;
            result_reg  <= '0;
        end else begin
            done_reg    <= done_next;
            error_reg   <= error_next;
            overrun_reg <= overrun_next;
            result_reg  <= result_next;
        end
    end

    assign done    = done_reg;
    assign error   = error_reg;
    assign overrun = overrun_reg;
    assign result  = result_reg;

endmodule
